// File: rtl/ula_seq.sv
// Four-state operand/writeback sequencer around the external 16-bit ALU.
// Reads two operands from an 8x16 register bank, drives the ALU, and writes the result back.
module ula_seq #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s,
    output logic             done,
    output logic             illegal,
    output logic             zero,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b111;

    logic [1:0]       stateReg;
    logic [15:0]      instrReg;
    logic [2:0]       aluOpReg;
    logic [WIDTH-1:0] aluAReg;
    logic [WIDTH-1:0] aluBReg;
    logic [WIDTH-1:0] resultReg;
    logic             doneReg;
    logic             illegalReg;
    logic             zeroReg;

    logic [WIDTH-1:0] bankRd [NREGS];

    logic [2:0]       opField;
    logic [2:0]       rdField;
    logic [2:0]       rs1Field;
    logic [2:0]       rs2Field;
    logic [9:0]       imm10;
    logic [WIDTH-1:0] immExt;
    logic             isIllegal;
    logic             isLdi;
    logic             writeEn;

    assign opField   = instrReg[15:13];
    assign rdField   = instrReg[12:10];
    assign rs1Field  = instrReg[9:7];
    assign rs2Field  = instrReg[6:4];
    assign imm10     = instrReg[9:0];
    assign immExt    = {{(WIDTH-10){imm10[9]}}, imm10};
    assign isIllegal = (opField == 3'b101) || (opField == 3'b110);
    assign isLdi     = (opField == OP_LDI);
    assign writeEn   = (stateReg == WB) && !isIllegal && (rdField != 3'd0);

    // r0 has no storage: it is hardwired to zero so writes to it simply vanish.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : gBank
            if (gi == 0) begin : gZero
                assign bankRd[gi] = '0;
            end else begin : gReg
                logic [WIDTH-1:0] regQ;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        regQ <= '0;
                    end else if (writeEn && (rdField == 3'(gi))) begin
                        regQ <= resultReg;
                    end
                end
                assign bankRd[gi] = regQ;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            instrReg   <= '0;
            aluOpReg   <= OP_ADD;
            aluAReg    <= '0;
            aluBReg    <= '0;
            resultReg  <= '0;
            doneReg    <= 1'b0;
            illegalReg <= 1'b0;
            zeroReg    <= 1'b0;
        end else begin
            doneReg    <= 1'b0;
            illegalReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (instr_valid) begin
                        instrReg <= instr;
                        stateReg <= READ;
                    end
                end
                READ: begin
                    // LDI rides through the ALU as imm + 0; illegal ops leave the ALU inputs alone.
                    if (isLdi) begin
                        aluOpReg <= OP_ADD;
                        aluAReg  <= immExt;
                        aluBReg  <= '0;
                    end else if (!isIllegal) begin
                        aluOpReg <= opField;
                        aluAReg  <= bankRd[rs1Field];
                        aluBReg  <= bankRd[rs2Field];
                    end
                    stateReg <= EXEC;
                end
                EXEC: begin
                    resultReg <= alu_s;
                    stateReg  <= WB;
                end
                WB: begin
                    doneReg    <= 1'b1;
                    illegalReg <= isIllegal;
                    if (!isIllegal) begin
                        zeroReg <= (resultReg == '0);
                    end
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign instr_ready = (stateReg == IDLE);
    assign alu_op      = aluOpReg;
    assign alu_a       = aluAReg;
    assign alu_b       = aluBReg;
    assign done        = doneReg;
    assign illegal     = illegalReg;
    assign zero        = zeroReg;
    assign dbg_data    = bankRd[dbg_sel];

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: a table of instructions with hand-computed bank contents,
// then held-valid throttling and a reset-in-EXEC abort.
module tb_ula_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_s;
    logic        done;
    logic        illegal;
    logic        zero;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    ula_seq #(.NREGS(8), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .done(done), .illegal(illegal), .zero(zero),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream combinational ALU.
    always_comb begin
        alu_s = 16'h0;
        case (alu_op)
            3'b000: alu_s = alu_a + alu_b;
            3'b001: alu_s = alu_a - alu_b;
            3'b010: alu_s = alu_a & alu_b;
            3'b011: alu_s = alu_a | alu_b;
            3'b100: alu_s = alu_a ^ alu_b;
            default: alu_s = 16'h0;
        endcase
    end

    typedef struct {
        logic [15:0] ins;
        logic [2:0]  chkReg;
        logic [15:0] expData;
        logic        expZero;
        logic        expIll;
        logic [2:0]  expOp;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [15:0] rType(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'h0};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b111, rd, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake one instruction from IDLE and follow it until done (bounded).
    task automatic issue(input logic [15:0] ins, output int lat, output int lowCnt,
                         output logic [2:0] execOp, output logic ill);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        lat    = 0;
        lowCnt = instr_ready ? 0 : 1;
        execOp = 3'b000;
        ill    = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) execOp = alu_op;
            if (done) begin
                ill = illegal;
                break;
            end
            if (!instr_ready) lowCnt++;
        end
    endtask

    initial begin
        int          lat;
        int          lowCnt;
        logic [2:0]  execOp;
        logic        ill;
        int          doneCnt;
        logic        doneSeen;
        logic [15:0] addR1;

        vecs[0]  = '{ldi(3'd1, 10'h005),                  3'd1, 16'h0005, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{ldi(3'd2, 10'h3FD),                  3'd2, 16'hFFFD, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{rType(3'b000, 3'd3, 3'd1, 3'd2),     3'd3, 16'h0002, 1'b0, 1'b0, 3'b000};
        vecs[3]  = '{rType(3'b001, 3'd4, 3'd2, 3'd1),     3'd4, 16'hFFF8, 1'b0, 1'b0, 3'b001};
        vecs[4]  = '{ldi(3'd1, 10'h21E),                  3'd1, 16'hFE1E, 1'b0, 1'b0, 3'b000};
        vecs[5]  = '{rType(3'b000, 3'd1, 3'd1, 3'd1),     3'd1, 16'hFC3C, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{rType(3'b000, 3'd1, 3'd1, 3'd1),     3'd1, 16'hF878, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{rType(3'b000, 3'd1, 3'd1, 3'd1),     3'd1, 16'hF0F0, 1'b0, 1'b0, 3'b000};
        vecs[8]  = '{ldi(3'd2, 10'h1FE),                  3'd2, 16'h01FE, 1'b0, 1'b0, 3'b000};
        vecs[9]  = '{rType(3'b000, 3'd2, 3'd2, 3'd2),     3'd2, 16'h03FC, 1'b0, 1'b0, 3'b000};
        vecs[10] = '{rType(3'b000, 3'd2, 3'd2, 3'd2),     3'd2, 16'h07F8, 1'b0, 1'b0, 3'b000};
        vecs[11] = '{rType(3'b000, 3'd2, 3'd2, 3'd2),     3'd2, 16'h0FF0, 1'b0, 1'b0, 3'b000};
        vecs[12] = '{rType(3'b010, 3'd5, 3'd1, 3'd2),     3'd5, 16'h00F0, 1'b0, 1'b0, 3'b010};
        vecs[13] = '{rType(3'b011, 3'd6, 3'd1, 3'd2),     3'd6, 16'hFFF0, 1'b0, 1'b0, 3'b011};
        vecs[14] = '{rType(3'b100, 3'd7, 3'd1, 3'd2),     3'd7, 16'hFF00, 1'b0, 1'b0, 3'b100};
        vecs[15] = '{rType(3'b100, 3'd7, 3'd7, 3'd7),     3'd7, 16'h0000, 1'b1, 1'b0, 3'b100};
        vecs[16] = '{rType(3'b101, 3'd3, 3'd1, 3'd2),     3'd3, 16'h0002, 1'b1, 1'b1, 3'b100};
        vecs[17] = '{rType(3'b000, 3'd0, 3'd1, 3'd1),     3'd0, 16'h0000, 1'b0, 1'b0, 3'b000};
        vecs[18] = '{rType(3'b110, 3'd5, 3'd1, 3'd2),     3'd5, 16'h00F0, 1'b0, 1'b1, 3'b000};
        vecs[19] = '{ldi(3'd1, 10'h200),                  3'd1, 16'hFE00, 1'b0, 1'b0, 3'b000};

        // Reset state while rst is still held.
        #3;
        chk("reset instr_ready", 32'(instr_ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset zero", 32'(zero), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_b", 32'(alu_b), 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1;
            chk($sformatf("reset bank r%0d", r), 32'(dbg_data), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].ins, lat, lowCnt, execOp, ill);
            dbg_sel = vecs[i].chkReg;
            #1;
            chk($sformatf("v%0d done latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d ready low cycles", i), 32'(lowCnt), 32'd3);
            chk($sformatf("v%0d alu_op in EXEC", i), 32'(execOp), 32'(vecs[i].expOp));
            chk($sformatf("v%0d illegal", i), 32'(ill), 32'(vecs[i].expIll));
            chk($sformatf("v%0d r%0d", i, vecs[i].chkReg), 32'(dbg_data), 32'(vecs[i].expData));
            chk($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].expZero));
            $display("vec %0d instr=%04h r%0d=%04h zero=%0b illegal=%0b latency=%0d",
                     i, vecs[i].ins, vecs[i].chkReg, dbg_data, zero, ill, lat);
        end

        // Valid held high with junk LDI r7 while busy: only ADD r1,r1,r1 may run.
        addR1   = rType(3'b000, 3'd1, 3'd1, 3'd1);
        doneCnt = 0;
        dbg_sel = 3'd1;
        instr_valid = 1'b1;
        for (int c = 0; c < 60 && doneCnt < 8; c++) begin
            instr = instr_ready ? addR1 : ldi(3'd7, 10'(c + 1));
            @(posedge clk);
            #1;
            if (done) begin
                doneCnt++;
                $display("held-valid retire %0d r1=%04h zero=%0b", doneCnt, dbg_data, zero);
                if (doneCnt == 6) chk("held r1 reaches 0x8000", 32'(dbg_data), 32'h8000);
                if (doneCnt == 7) chk("held 0x8000+0x8000", 32'(dbg_data), 32'h0000);
            end
        end
        instr_valid = 1'b0;
        instr       = 16'h0;
        #1;
        chk("held retire count", 32'(doneCnt), 32'd8);
        chk("held final r1", 32'(dbg_data), 32'h0000);
        chk("held final zero", 32'(zero), 32'd1);
        dbg_sel = 3'd7;
        #1;
        chk("held junk not executed r7", 32'(dbg_data), 32'h0000);

        // Reset asserted in EXEC of ADD r3,r1,r2 aborts the instruction.
        instr       = rType(3'b000, 3'd3, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-abort alu_b (r2)", 32'(alu_b), 32'h0FF0);
        rst = 1'b1;
        #1;
        chk("abort alu_op", 32'(alu_op), 32'd0);
        chk("abort alu_a", 32'(alu_a), 32'd0);
        chk("abort alu_b", 32'(alu_b), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort zero", 32'(zero), 32'd0);
        chk("abort instr_ready", 32'(instr_ready), 32'd1);
        dbg_sel = 3'd2;
        #1;
        chk("abort bank r2", 32'(dbg_data), 32'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        doneSeen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            doneSeen = doneSeen | done;
        end
        dbg_sel = 3'd3;
        #1;
        chk("abort no done pulse", 32'(doneSeen), 32'd0);
        chk("abort ready after release", 32'(instr_ready), 32'd1);
        chk("abort no writeback r3", 32'(dbg_data), 32'h0000);
        $display("abort: done_seen=%0b ready=%0b r3=%04h", doneSeen, instr_ready, dbg_data);

        // FSM restarts cleanly after the abort.
        issue(ldi(3'd1, 10'h005), lat, lowCnt, execOp, ill);
        dbg_sel = 3'd1;
        #1;
        chk("post-abort latency", 32'(lat), 32'd3);
        chk("post-abort r1", 32'(dbg_data), 32'h0005);
        $display("post-abort LDI r1=%04h latency=%0d", dbg_data, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
